// File: rtl/br_resolve_if.sv
// Request/result handshake bundle between the issue logic and the branch resolution unit.
interface br_resolve_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [2:0]      in_func;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
    logic [XLEN-1:0] out_target;
    logic [XLEN-1:0] out_next_pc;

    modport master (
        output in_valid, in_a, in_b, in_func, in_pc, in_imm, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_target, out_next_pc
    );

    modport slave (
        input  in_valid, in_a, in_b, in_func, in_pc, in_imm, in_pred_taken, out_ready,
        output in_ready, out_valid, out_taken, out_mispredict, out_illegal, out_target, out_next_pc
    );
endinterface

// File: rtl/br_resolve.sv
// Two-stage branch resolution: S1 latches operands, S2 holds the resolved
// taken/target/redirect result; saturating mispredict counter on delivery.
module br_resolve #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    br_resolve_if.slave      bus,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4'd4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    // Returns {illegal, taken}; unused encodings resolve as not-taken.
    function automatic logic [1:0] eval_branch(input logic [2:0] func,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic [1:0] r;
        case (func)
            3'd0:    r = {1'b0, a == b};
            3'd1:    r = {1'b0, a != b};
            3'd2:    r = {1'b0, $signed(a) <  $signed(b)};
            3'd3:    r = {1'b0, $signed(a) >= $signed(b)};
            3'd4:    r = {1'b0, a <  b};
            3'd5:    r = {1'b0, a >= b};
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    logic            s1_valid_r;
    logic [XLEN-1:0] s1_a_r;
    logic [XLEN-1:0] s1_b_r;
    logic [XLEN-1:0] s1_pc_r;
    logic [XLEN-1:0] s1_imm_r;
    logic [2:0]      s1_func_r;
    logic            s1_pred_r;

    logic            s2_valid_r;
    logic            s2_taken_r;
    logic            s2_mis_r;
    logic            s2_ill_r;
    logic [XLEN-1:0] s2_target_r;
    logic [XLEN-1:0] s2_next_pc_r;
    logic [CNT_W-1:0] cnt_r;

    logic            s2_adv_s;
    logic            in_hs_s;
    logic            out_hs_s;
    logic            taken_s;
    logic            illegal_s;
    logic            mis_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] next_pc_s;

    // Stage-advance and handshake decisions.
    always_comb begin
        s2_adv_s     = !s2_valid_r || bus.out_ready;
        bus.in_ready = !flush && (!s1_valid_r || s2_adv_s);
        in_hs_s      = bus.in_valid && bus.in_ready;
        out_hs_s     = s2_valid_r && bus.out_ready && !flush;
    end

    // Resolve the branch held in S1.
    always_comb begin
        {illegal_s, taken_s} = eval_branch(s1_func_r, s1_a_r, s1_b_r);
        target_s  = s1_pc_r + s1_imm_r;
        next_pc_s = taken_s ? target_s : (s1_pc_r + PC_STEP);
        mis_s     = !illegal_s && (taken_s != s1_pred_r);
    end

    // S1: operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_pc_r    <= '0;
            s1_imm_r   <= '0;
            s1_func_r  <= 3'd0;
            s1_pred_r  <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (in_hs_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= bus.in_a;
            s1_b_r     <= bus.in_b;
            s1_pc_r    <= bus.in_pc;
            s1_imm_r   <= bus.in_imm;
            s1_func_r  <= bus.in_func;
            s1_pred_r  <= bus.in_pred_taken;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // S2: resolved result; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_taken_r   <= 1'b0;
            s2_mis_r     <= 1'b0;
            s2_ill_r     <= 1'b0;
            s2_target_r  <= '0;
            s2_next_pc_r <= '0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_taken_r   <= taken_s;
                s2_mis_r     <= mis_s;
                s2_ill_r     <= illegal_s;
                s2_target_r  <= target_s;
                s2_next_pc_r <= next_pc_s;
            end
        end
    end

    // Mispredict counter: counts delivered results only, clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (out_hs_s && s2_mis_r && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign bus.out_valid      = s2_valid_r;
    assign bus.out_taken      = s2_taken_r;
    assign bus.out_mispredict = s2_mis_r;
    assign bus.out_illegal    = s2_ill_r;
    assign bus.out_target     = s2_target_r;
    assign bus.out_next_pc    = s2_next_pc_r;
    assign mispred_cnt        = cnt_r;
endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/address width (>= 8).
REQ-002 SHALL have parameter CNT_W, default 16, mispredict counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-007 SHALL have ports in_a, in_b  input  XLEN each  compare operands.
REQ-008 SHALL have port in_func  input  3  branch function.
REQ-009 SHALL have ports in_pc, in_imm  input  XLEN each  branch PC and offset.
REQ-010 SHALL have port in_pred_taken  input  1  front-end prediction.
REQ-011 SHALL have port flush  input  1  discard all in-flight requests.
REQ-012 SHALL have port cnt_clr  input  1  synchronous clear of mispred_cnt.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have ports out_taken, out_mispredict, out_illegal  output  1 each  resolved result flags.
REQ-016 SHALL have ports out_target, out_next_pc  output  XLEN each  branch target and redirect PC.
REQ-017 SHALL have port mispred_cnt  output  CNT_W  saturating mispredict count.

Function
REQ-018 in_func encoding SHALL be: 000 beq, 001 bne, 010 blt (signed), 011 bge (signed), 100 bltu, 101 bgeu; 110/111 illegal.
REQ-019 Illegal func SHALL give out_taken=0, out_illegal=1, out_mispredict=0; never X.
REQ-020 out_target SHALL equal (in_pc + in_imm) mod 2^XLEN; wrap-around discarded.
REQ-021 out_next_pc SHALL equal out_target when taken, else (in_pc + 4) mod 2^XLEN.
REQ-022 out_mispredict SHALL equal (out_taken != in_pred_taken) for legal funcs.
REQ-023 Datapath SHALL be two register stages: S1 latches operands and computes taken/target; S2 holds final outputs.
REQ-024 With out_ready=1 and no stall, result SHALL appear with out_valid=1 exactly 2 cycles after acceptance; throughput 1 per cycle.
REQ-025 A stage SHALL advance only when the next stage is empty or advancing; out_ready=0 SHALL hold S2 contents and outputs stable.
REQ-026 in_ready SHALL be !flush && (S1 empty || S1 advancing) (combinational); no request lost or duplicated under backpressure.
REQ-027 flush=1 SHALL invalidate S1 and S2 at the next edge; in_valid ignored in that cycle; out_valid=0 the cycle after.
REQ-028 mispred_cnt SHALL increment on each output handshake (out_valid && out_ready) with out_mispredict=1, saturating at 2^CNT_W-1.
REQ-029 cnt_clr SHALL zero mispred_cnt at next edge, overriding a simultaneous increment.
REQ-030 Flushed entries SHALL never count.

Reset
REQ-031 rst_n=0 SHALL asynchronously clear S1/S2 valid, all out_* data/flag outputs to 0, and mispred_cnt to 0.
REQ-032 During and after reset in_ready SHALL be 1 (flush=0); out_valid SHALL be 0 until the first accepted request drains.
REQ-033 Reset asserted mid-operation SHALL discard in-flight requests without producing a handshake.

Verification
REQ-034 beq a=5,b=5,pc=0x100,imm=0x20,pred=0 -> 2 cycles later taken=1, target=next_pc=0x120, mispredict=1, cnt=1.
REQ-035 blt a=0xFFFFFFFF,b=1 -> taken=1; bltu same operands -> taken=0, next_pc=pc+4.
REQ-036 pc=0xFFFFFFF0, imm=0x20, func=110 -> target=0x10, illegal=1, taken=0, mispredict=0, cnt unchanged.
REQ-037 back-to-back 4 requests with out_ready low for 3 cycles mid-stream -> in_ready drops, all 4 results delivered in order, outputs stable while stalled.
REQ-038 flush with 2 in flight, then new request -> only new result emerges; with CNT_W=2, 5 mispredicts -> cnt=3; cnt_clr together with mispredict handshake -> cnt=0.
